// File: rtl/color_pkg.sv
// Shared Color FSM definitions: state encoding, output codes and reset state.
package color_pkg;

    typedef enum logic {
        Blue = 1'b0,
        Red  = 1'b1
    } Color_state;

    localparam logic [1:0] CODE_BLUE = 2'h1;
    localparam logic [1:0] CODE_RED  = 2'h2;

    localparam Color_state RST_STATE = Red;

endpackage

// File: rtl/color_fsm_decoder_if.sv
// Code stream in / decoded result out link for the Color FSM decoder.
interface color_fsm_decoder_if;
    import color_pkg::*;

    logic       code_valid;
    logic [1:0] code;
    logic       code_ready;
    logic       dec_valid;
    logic       dec_ready;
    logic       dec_toggle;
    Color_state dec_state;
    logic       dec_err;

    modport master (
        output code_valid, code, dec_ready,
        input  code_ready, dec_valid, dec_toggle, dec_state, dec_err
    );

    modport slave (
        input  code_valid, code, dec_ready,
        output code_ready, dec_valid, dec_toggle, dec_state, dec_err
    );

endinterface

// File: rtl/color_sat_counter.sv
// Saturating up-counter; an increment coinciding with clr yields 1.
module color_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (clr)
                count <= ONE;
            else if (count != '1)
                count <= count + ONE;
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/color_fsm_decoder.sv
// Shadow-state decoder for the Color FSM code stream.
// COLOR_FSM_DECODER_ERRCNT_EN adds err_cnt and post-error resync.
module color_fsm_decoder
    import color_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    color_fsm_decoder_if.slave   link,
    output logic                 err_sticky,
`ifdef COLOR_FSM_DECODER_ERRCNT_EN
    output logic [CNT_WIDTH-1:0] err_cnt,
`endif
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    Color_state state;
    Color_state state_n;
    logic       accept;
    logic       tog;
    logic       err;

`ifdef COLOR_FSM_DECODER_ERRCNT_EN
    logic       resync;
`endif

    assign link.code_ready = !rst && (!link.dec_valid || link.dec_ready);
    assign accept = link.code_valid && link.code_ready;

    always_comb begin
        state_n = state;
        tog     = 1'b0;
        err     = 1'b0;
        unique case (1'b1)
            (link.code == CODE_BLUE): begin
                state_n = Blue;
                tog     = (state == Red);
            end
            (link.code == CODE_RED): begin
                state_n = Red;
                tog     = (state == Blue);
            end
            default: err = 1'b1;
        endcase
`ifdef COLOR_FSM_DECODER_ERRCNT_EN
        // First legal code after an error re-locks without a toggle
        if (resync)
            tog = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RST_STATE;
        else if (accept)
            state <= state_n;
    end

`ifdef COLOR_FSM_DECODER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            resync <= 1'b0;
        else if (accept)
            resync <= err;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            link.dec_valid  <= 1'b0;
            link.dec_toggle <= 1'b0;
            link.dec_state  <= RST_STATE;
            link.dec_err    <= 1'b0;
        end else if (accept) begin
            link.dec_valid  <= 1'b1;
            link.dec_toggle <= tog;
            link.dec_state  <= state_n;
            link.dec_err    <= err;
        end else if (link.dec_ready) begin
            link.dec_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_sticky <= 1'b0;
        else if (accept && err)
            err_sticky <= 1'b1;
        else if (clr)
            err_sticky <= 1'b0;
    end

    color_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tog_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && tog),
        .clr   (clr),
        .count (toggle_cnt)
    );

`ifdef COLOR_FSM_DECODER_ERRCNT_EN
    color_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && err),
        .clr   (clr),
        .count (err_cnt)
    );
`endif

endmodule
